// File: rtl/keys_snapshot_sched_pkg.sv
// Shared constants, FSM state type and key-padding helpers for the key snapshot scheduler.
package keys_snapshot_sched_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LATCH,
      ST_WRITE,
      ST_STAMP
   } state_t;

   // Number of 8-key groups needed to hold n keys.
   function automatic int groups_of(input int n);
      return (n + 7) / 8;
   endfunction

   // Width of the key vector once padded up to a whole number of groups.
   function automatic int padded_width(input int n);
      return 8 * groups_of(n);
   endfunction

endpackage

// File: rtl/keys_snapshot_sched_if.sv
// SPI read port and single-port RAM port of the key snapshot scheduler.
interface keys_snapshot_sched_if;
   import keys_snapshot_sched_pkg::*;

   logic              rd_req_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic              rd_ack_o;
   logic [DATA_W-1:0] rd_data_o;
   logic              ram_en_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_wdata_o;
   logic [DATA_W-1:0] ram_rdata_i;

   // Scheduler side.
   modport master (
      input  rd_req_i, rd_addr_i, ram_rdata_i,
      output rd_ack_o, rd_data_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

   // SPI slave / RAM side.
   modport slave (
      output rd_req_i, rd_addr_i, ram_rdata_i,
      input  rd_ack_o, rd_data_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

endinterface

// File: rtl/keys_snapshot_sched_group_mux.sv
// Selects one 8-key byte out of the padded snapshot shadow by group index.
module keys_group_mux
   import keys_snapshot_sched_pkg::*;
#(
   parameter int GROUPS = 8
) (
   input  logic [8*GROUPS-1:0] shadow,
   input  logic [ADDR_W-1:0]   group,
   output logic [DATA_W-1:0]   data
);

   logic [DATA_W-1:0] grp_bytes [GROUPS];

   generate
      for (genvar gi = 0; gi < GROUPS; gi++) begin : g_split
         assign grp_bytes[gi] = shadow[8*gi +: 8];
      end
   endgenerate

   // Index beyond the last group yields zero rather than a stale byte.
   always_comb begin
      data = '0;
      for (int i = 0; i < GROUPS; i++) begin
         if (group == ADDR_W'(i)) begin
            data = grp_bytes[i];
         end
      end
   end

endmodule

// File: rtl/keys_snapshot_sched.sv
// Key-state RAM owner: periodic coherent key snapshots written group by group,
// sequence stamping, and per-cycle arbitration where SPI reads always win.
module keys_snapshot_sched
   import keys_snapshot_sched_pkg::*;
#(
   parameter int NUM_KEYS = 61,
   parameter int SCAN_DIV = 470
) (
   input  logic                  clk_g_i,
   input  logic                  rst_g_i,
   input  logic [NUM_KEYS-1:0]   keys_i,
   keys_snapshot_sched_if.master bus,
   output logic [7:0]            snap_seq_o,
   output logic                  busy_o
);

   localparam int                GROUPS     = groups_of(NUM_KEYS);
   localparam int                SHADOW_W   = padded_width(NUM_KEYS);
   localparam logic [ADDR_W-1:0] SEQ_ADDR   = ADDR_W'(GROUPS);
   localparam logic [ADDR_W-1:0] LAST_GROUP = ADDR_W'(GROUPS - 1);
   localparam logic [31:0]       TIMER_LAST = 32'(SCAN_DIV - 1);

   state_t              state_reg, state_next;
   logic [31:0]         timer_reg, timer_next;
   logic [ADDR_W-1:0]   idx_reg, idx_next;
   logic [SHADOW_W-1:0] shadow_reg;
   logic [7:0]          seq_reg;
   logic                ack_reg;
   logic                from_ram_reg;
   logic [DATA_W-1:0]   data_hold_reg;

   logic [SHADOW_W-1:0] keys_padded;
   logic [DATA_W-1:0]   group_byte;
   logic                rd_in_range;
   logic                rd_grant;
   logic                wr_want;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                latch_now;
   logic                seq_bump;
   logic                ram_en;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   rd_data;

   // Pad bits above the last real key are tied to zero.
   generate
      for (genvar gi = 0; gi < SHADOW_W; gi++) begin : g_pad
         if (gi < NUM_KEYS) begin : g_key
            assign keys_padded[gi] = keys_i[gi];
         end else begin : g_zero
            assign keys_padded[gi] = 1'b0;
         end
      end
   endgenerate

   keys_group_mux #(
      .GROUPS (GROUPS)
   ) u_group_mux (
      .shadow (shadow_reg),
      .group  (idx_reg),
      .data   (group_byte)
   );

   // A read is only granted the RAM for in-range addresses outside INIT.
   assign rd_in_range = (bus.rd_addr_i <= SEQ_ADDR);
   assign rd_grant    = !rst_g_i && bus.rd_req_i && rd_in_range && (state_reg != ST_INIT);

   // Next-state logic; a write step advances only when the read side left the RAM free.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      idx_next   = idx_reg;
      wr_want    = 1'b0;
      wr_addr    = idx_reg;
      wr_data    = '0;
      latch_now  = 1'b0;
      seq_bump   = 1'b0;
      case (state_reg)
         ST_INIT: begin
            wr_want = 1'b1;
            if (!rd_grant) begin
               if (idx_reg == SEQ_ADDR) begin
                  idx_next   = '0;
                  state_next = ST_IDLE;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (timer_reg == TIMER_LAST) begin
               timer_next = '0;
               state_next = ST_LATCH;
            end else begin
               timer_next = timer_reg + 32'd1;
            end
         end
         ST_LATCH: begin
            latch_now  = 1'b1;
            idx_next   = '0;
            state_next = ST_WRITE;
         end
         ST_WRITE: begin
            wr_want = 1'b1;
            wr_data = group_byte;
            if (!rd_grant) begin
               if (idx_reg == LAST_GROUP) begin
                  idx_next   = '0;
                  state_next = ST_STAMP;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
         end
         ST_STAMP: begin
            wr_want = 1'b1;
            wr_addr = SEQ_ADDR;
            wr_data = seq_reg + 8'd1;
            if (!rd_grant) begin
               seq_bump   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // RAM port arbitration: read first, then pending write, otherwise idle; reset silences the port.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rd_grant) begin
         ram_en   = 1'b1;
         ram_addr = bus.rd_addr_i;
      end else if (wr_want && !rst_g_i) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end
   end

   // FSM, idle timer, group index and sequence counter.
   always_ff @(posedge clk_g_i) begin
      if (rst_g_i) begin
         state_reg <= ST_INIT;
         timer_reg <= '0;
         idx_reg   <= '0;
         seq_reg   <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         idx_reg   <= idx_next;
         if (seq_bump) begin
            seq_reg <= seq_reg + 8'd1;
         end
      end
   end

   // Coherent shadow copy of the keys, taken once per snapshot.
   always_ff @(posedge clk_g_i) begin
      if (latch_now && !rst_g_i) begin
         shadow_reg <= keys_padded;
      end
   end

   // Read response pipe: ack one cycle after the request, data held until the next ack.
   always_ff @(posedge clk_g_i) begin
      if (rst_g_i) begin
         ack_reg       <= 1'b0;
         from_ram_reg  <= 1'b0;
         data_hold_reg <= '0;
      end else begin
         ack_reg      <= bus.rd_req_i;
         from_ram_reg <= rd_grant;
         if (ack_reg) begin
            data_hold_reg <= rd_data;
         end
      end
   end

   // RAM output is only meaningful in the ack cycle; afterwards the held copy is shown.
   always_comb begin
      rd_data = data_hold_reg;
      if (ack_reg) begin
         rd_data = from_ram_reg ? bus.ram_rdata_i : '0;
      end
   end

   assign bus.ram_en_o    = ram_en;
   assign bus.ram_we_o    = ram_we;
   assign bus.ram_addr_o  = ram_addr;
   assign bus.ram_wdata_o = ram_wdata;
   assign bus.rd_ack_o    = ack_reg && !rst_g_i;
   assign bus.rd_data_o   = rst_g_i ? '0 : rd_data;
   assign snap_seq_o      = rst_g_i ? '0 : seq_reg;
   assign busy_o          = !rst_g_i && (state_reg != ST_IDLE);

endmodule

// File: tb/tb_keys_snapshot_sched.sv
// Self-checking bench for keys_snapshot_sched: RAM model, expected snapshot model and directed/random reads.
module tb_keys_snapshot_sched;

   localparam int NUM_KEYS = 61;
   localparam int SCAN_DIV = 40;
   localparam int GROUPS   = (NUM_KEYS + 7) / 8;
   localparam int BUDGET   = 400;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NUM_KEYS-1:0] keys = '0;
   logic [7:0]          snap_seq;
   logic                busy;

   keys_snapshot_sched_if bus ();

   always #5 clk = ~clk;

   keys_snapshot_sched #(
      .NUM_KEYS (NUM_KEYS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk_g_i    (clk),
      .rst_g_i    (rst),
      .keys_i     (keys),
      .bus        (bus),
      .snap_seq_o (snap_seq),
      .busy_o     (busy)
   );

   // Single-port RAM with one-cycle registered read.
   logic [7:0] mem [512];
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      bus.ram_rdata_i = '0;
   end
   always @(posedge clk) begin
      if (bus.ram_en_o) begin
         if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
         else              bus.ram_rdata_i <= mem[bus.ram_addr_o];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: keys captured at the latch point and number of completed snapshots.
   logic [NUM_KEYS-1:0] snap_keys = '0;
   int                  exp_seq   = 0;

   function automatic logic [7:0] exp_byte(input int addr);
      logic [7:0] b;
      b = '0;
      if (addr < GROUPS) begin
         for (int k = 0; k < 8; k++) begin
            if (8 * addr + k < NUM_KEYS) b[k] = snap_keys[8 * addr + k];
         end
      end else if (addr == GROUPS) begin
         b = 8'(exp_seq % 256);
      end
      return b;
   endfunction

   logic       obs_en, obs_we;
   logic [8:0] obs_addr;

   // One read transaction: request this cycle, ack and data sampled one cycle later.
   task automatic rd(input logic [8:0] a, output logic [7:0] d);
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = a;
      #1;
      obs_en   = bus.ram_en_o;
      obs_we   = bus.ram_we_o;
      obs_addr = bus.ram_addr_o;
      @(negedge clk);
      check_val("rd_ack", 32'(bus.rd_ack_o), 32'd1);
      d = bus.rd_data_o;
      bus.rd_req_i = 1'b0;
      $display("rd addr=0x%03h data=0x%02h ram_en=%0b ram_we=%0b", a, d, obs_en, obs_we);
   endtask

   task automatic rd_chk(input logic [8:0] a, input logic [7:0] exp, input string tag);
      logic [7:0] d;
      rd(a, d);
      check_val(tag, 32'(d), 32'(exp));
      if (int'(a) <= GROUPS) check_val({tag, "_acc"}, 32'({obs_en, obs_we, obs_addr}), 32'({1'b1, 1'b0, a}));
      else                   check_val({tag, "_acc"}, 32'(obs_en), 32'd0);
   endtask

   task automatic check_all(input string tag);
      for (int a = 0; a <= GROUPS; a++) rd_chk(9'(a), exp_byte(a), tag);
   endtask

   task automatic wait_busy(input logic lvl, output int n);
      n = 0;
      while (busy !== lvl && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (busy !== lvl) check_val("busy_timeout", 32'(busy), 32'(lvl));
   endtask

   task automatic wait_latch(output int n);
      wait_busy(1'b1, n);
      snap_keys = keys;
   endtask

   task automatic wait_done();
      int n;
      wait_busy(1'b0, n);
      exp_seq++;
   endtask

   function automatic logic [NUM_KEYS-1:0] rand_keys();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[NUM_KEYS-1:0];
   endfunction

   initial begin
      logic [7:0] d;
      int         n;
      bus.rd_req_i  = 1'b0;
      bus.rd_addr_i = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_ack",   32'(bus.rd_ack_o),    0);
      check_val("rst_data",  32'(bus.rd_data_o),   0);
      check_val("rst_en",    32'(bus.ram_en_o),    0);
      check_val("rst_we",    32'(bus.ram_we_o),    0);
      check_val("rst_addr",  32'(bus.ram_addr_o),  0);
      check_val("rst_wdata", 32'(bus.ram_wdata_o), 0);
      check_val("rst_seq",   32'(snap_seq),        0);
      check_val("rst_busy",  32'(busy),            0);

      // Read on the first INIT cycle: acked, zero data, RAM busy with the INIT write
      rst = 1'b0;
      rd(9'd0, d);
      check_val("init_rd_data", 32'(d), 0);
      check_val("init_no_rd",   32'(obs_en && !obs_we), 0);
      check_val("init_wr0",     32'({obs_we, obs_addr}), 32'({1'b1, 9'd0}));
      wait_busy(1'b0, n);
      check_all("init_zero");

      // Directed snapshot: keys 0 and 60
      keys = '0;
      keys[0]  = 1'b1;
      keys[60] = 1'b1;
      wait_latch(n);
      wait_done();
      rd_chk(9'd0, 8'h01, "snap_a0");
      rd_chk(9'd7, 8'h10, "snap_a7");
      rd_chk(9'd8, 8'h01, "snap_seq_byte");
      check_val("snap_seq_o", 32'(snap_seq), 1);

      // Coherence: key 9 changes right after the latch
      keys = rand_keys();
      keys[9] = 1'b1;
      wait_latch(n);
      @(negedge clk);
      keys[9] = 1'b0;
      wait_done();
      rd_chk(9'd1, exp_byte(1), "coh_keep");
      check_val("coh_bit9", 32'(snap_keys[9]), 1);
      wait_latch(n);
      wait_done();
      rd_chk(9'd1, exp_byte(1), "coh_next");

      // Read collision during WRITE: every read granted, writer stalls on group 0
      keys = rand_keys();
      wait_latch(n);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         logic [8:0] a;
         a = 9'($urandom_range(0, GROUPS));
         rd(a, d);
         check_val("coll_grant", 32'({obs_en, obs_we, obs_addr}), 32'({1'b1, 1'b0, a}));
      end
      #1;
      check_val("coll_busy",  32'(busy), 1);
      check_val("coll_stall", 32'({bus.ram_we_o, bus.ram_addr_o}), 32'({1'b1, 9'd0}));
      check_val("coll_wdata", 32'(bus.ram_wdata_o), 32'(exp_byte(0)));
      wait_done();
      check_all("coll");

      // Random snapshots with random out-of-range reads
      for (int r = 0; r < 6; r++) begin
         keys = rand_keys();
         wait_latch(n);
         wait_done();
         check_val("rnd_seq_o", 32'(snap_seq), 32'(exp_seq % 256));
         check_all("rnd");
         rd_chk(9'($urandom_range(GROUPS + 1, 511)), 8'h00, "rnd_oor");
      end

      // 256 back-to-back snapshots: idle spacing and sequence wrap
      for (int i = 0; i < 256; i++) begin
         wait_latch(n);
         if (i > 0) check_val("idle_len", 32'(n), 32'(SCAN_DIV));
         wait_done();
         check_val("wrap_seq_o", 32'(snap_seq), 32'(exp_seq % 256));
      end
      check_all("wrap");
      rd_chk(9'h1FF, 8'h00, "oor_1ff");

      // Reset mid-WRITE at group 3 with a simultaneous read request
      keys = rand_keys();
      wait_latch(n);
      repeat (4) @(negedge clk);
      check_val("mid_g3", 32'({bus.ram_we_o, bus.ram_addr_o}), 32'({1'b1, 9'd3}));
      rst           = 1'b1;
      bus.rd_req_i  = 1'b1;
      bus.rd_addr_i = 9'd0;
      @(negedge clk);
      rst          = 1'b0;
      bus.rd_req_i = 1'b0;
      #1;
      check_val("mid_no_ack", 32'(bus.rd_ack_o), 0);
      check_val("mid_busy",   32'(busy), 1);
      check_val("mid_seq",    32'(snap_seq), 0);
      exp_seq   = 0;
      snap_keys = '0;
      wait_busy(1'b0, n);
      check_all("rezero");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
